// File: rtl/perf_pkg.sv
// Shared types and widths for the windowed performance-counter sampler.
package perf_pkg;

  localparam int unsigned CNT_W      = 32;
  localparam int unsigned IDX_W      = 16;
  localparam int unsigned LEN_W      = 16;
  localparam int unsigned DROP_W     = 16;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] retire;
    logic [CNT_W-1:0] alu;
    logic [CNT_W-1:0] load;
    logic [CNT_W-1:0] store;
    logic [CNT_W-1:0] branch;
  } counts_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    counts_t          delta;
  } sample_t;

  // Field-wise modulo-2^32 difference, so a wrapped running counter still yields the true delta.
  function automatic counts_t count_delta(input counts_t now, input counts_t base);
    counts_t d;
    d.retire = now.retire - base.retire;
    d.alu    = now.alu    - base.alu;
    d.load   = now.load   - base.load;
    d.store  = now.store  - base.store;
    d.branch = now.branch - base.branch;
    return d;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO; the head entry is read straight from storage so outputs are register-driven.
module sample_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [OCC_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == OCC_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/perf_window_sampler.sv
// Samples running performance counters over fixed-length windows and queues per-window deltas.
module perf_window_sampler
  import perf_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [LEN_W-1:0]  window_len_i,
  input  logic [CNT_W-1:0]  retire_cnt_i,
  input  logic [CNT_W-1:0]  alu_cnt_i,
  input  logic [CNT_W-1:0]  load_cnt_i,
  input  logic [CNT_W-1:0]  store_cnt_i,
  input  logic [CNT_W-1:0]  branch_cnt_i,
  output logic              sample_valid_o,
  input  logic              sample_ready_i,
  output logic [IDX_W-1:0]  sample_idx_o,
  output logic [CNT_W-1:0]  sample_retire_o,
  output logic [CNT_W-1:0]  sample_alu_o,
  output logic [CNT_W-1:0]  sample_load_o,
  output logic [CNT_W-1:0]  sample_store_o,
  output logic [CNT_W-1:0]  sample_branch_o,
  output logic [DROP_W-1:0] drop_cnt_o,
  output logic              busy_o
);

  state_e           state;
  state_e           state_nxt;
  logic [LEN_W-1:0] win_ctr;
  logic [LEN_W-1:0] win_ctr_nxt;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] win_idx_nxt;
  counts_t          base;
  counts_t          base_nxt;
  counts_t          cur;
  logic             push;
  sample_t          push_data;
  sample_t          head;
  logic             fifo_full;
  logic             fifo_empty;

  assign cur = '{retire: retire_cnt_i, alu: alu_cnt_i, load: load_cnt_i,
                 store: store_cnt_i, branch: branch_cnt_i};

  assign push_data = '{idx: win_idx, delta: count_delta(cur, base)};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= ST_IDLE;
      win_ctr <= '0;
      win_idx <= '0;
      base    <= '0;
    end else begin
      state   <= state_nxt;
      win_ctr <= win_ctr_nxt;
      win_idx <= win_idx_nxt;
      base    <= base_nxt;
    end
  end

  // Window sequencing: win_ctr counts down the remaining cycles; zero closes the window.
  always_comb begin
    state_nxt   = state;
    win_ctr_nxt = win_ctr;
    win_idx_nxt = win_idx;
    base_nxt    = base;
    push        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable_i && (window_len_i != '0)) begin
          state_nxt   = ST_RUN;
          base_nxt    = cur;
          win_ctr_nxt = window_len_i - LEN_W'(1);
        end
      end
      ST_RUN: begin
        if (!enable_i || (window_len_i == '0)) begin
          state_nxt = ST_IDLE;
        end else if (win_ctr != '0) begin
          win_ctr_nxt = win_ctr - LEN_W'(1);
        end else begin
          push        = 1'b1;
          base_nxt    = cur;
          win_ctr_nxt = window_len_i - LEN_W'(1);
          win_idx_nxt = win_idx + IDX_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (sample_t)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (reset_i),
    .push      (push),
    .push_data (push_data),
    .pop       (sample_ready_i),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Lost samples: full FIFO with no pop freeing a slot in the push cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_cnt_o <= '0;
    end else if (push && fifo_full && !sample_ready_i && (drop_cnt_o != '1)) begin
      drop_cnt_o <= drop_cnt_o + DROP_W'(1);
    end
  end

  assign busy_o          = (state == ST_RUN);
  assign sample_valid_o  = !fifo_empty;
  assign sample_idx_o    = head.idx;
  assign sample_retire_o = head.delta.retire;
  assign sample_alu_o    = head.delta.alu;
  assign sample_load_o   = head.delta.load;
  assign sample_store_o  = head.delta.store;
  assign sample_branch_o = head.delta.branch;

endmodule
